// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: per-master request/AHB bundle on one side, the shared AHB master port on the other.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
) ();
    localparam int OWNER_W = $clog2(NUM_MASTERS);
    logic [NUM_MASTERS-1:0]        m_bus_req;
    logic [NUM_MASTERS-1:0]        m_bus_ack;
    logic [NUM_MASTERS*ADDR_W-1:0] m_haddr;
    logic [NUM_MASTERS-1:0]        m_hwrite;
    logic [NUM_MASTERS*4-1:0]      m_hsize;
    logic [NUM_MASTERS*3-1:0]      m_hburst;
    logic [NUM_MASTERS*4-1:0]      m_hprot;
    logic [NUM_MASTERS*2-1:0]      m_htrans;
    logic [NUM_MASTERS-1:0]        m_hmastlock;
    logic [NUM_MASTERS*DATA_W-1:0] m_hwdata;
    logic                          m_hready;
    logic                          m_hresp;
    logic                          m_hreset_n;
    logic [DATA_W-1:0]             m_hrdata;
    logic [ADDR_W-1:0]             haddr;
    logic                          hwrite;
    logic [3:0]                    hsize;
    logic [2:0]                    hburst;
    logic [3:0]                    hprot;
    logic [1:0]                    htrans;
    logic                          hmastlock;
    logic [DATA_W-1:0]             hwdata;
    logic                          hready;
    logic                          hresp;
    logic                          hreset_n;
    logic [DATA_W-1:0]             hrdata;
    logic [OWNER_W-1:0]            owner_id;
    logic                          bus_busy;

    // The arbiter sits on the slave side of the masters' requests
    modport slave (
        input  m_bus_req, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_htrans, m_hmastlock, m_hwdata,
        input  hready, hresp, hreset_n, hrdata,
        output m_bus_ack, m_hready, m_hresp, m_hreset_n, m_hrdata,
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, owner_id, bus_busy
    );

    modport master (
        output m_bus_req, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_htrans, m_hmastlock, m_hwdata,
        output hready, hresp, hreset_n, hrdata,
        input  m_bus_ack, m_hready, m_hresp, m_hreset_n, m_hrdata,
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, owner_id, bus_busy
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin N-master AHB arbiter muxing address phase by owner and data phase by dph_owner.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
) (
    input logic              clk,
    input logic              rst_n,
    ahb_bus_arbiter_if.slave bus
);
    localparam int OWNER_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    state_t             r_state, w_next_state;
    logic [OWNER_W-1:0] r_owner, r_last, r_dph_owner;
    logic [OWNER_W-1:0] w_next_owner, w_next_last, w_winner;
    logic               r_dph_active, w_own, w_any;
    int                 w_best;

    logic [ADDR_W-1:0] w_addr  [NUM_MASTERS];
    logic [DATA_W-1:0] w_wdata [NUM_MASTERS];
    logic [3:0]        w_size  [NUM_MASTERS];
    logic [2:0]        w_burst [NUM_MASTERS];
    logic [3:0]        w_prot  [NUM_MASTERS];
    logic [1:0]        w_trans [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_split
        assign w_addr[g]  = bus.m_haddr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = bus.m_hwdata[g*DATA_W +: DATA_W];
        assign w_size[g]  = bus.m_hsize[g*4 +: 4];
        assign w_burst[g] = bus.m_hburst[g*3 +: 3];
        assign w_prot[g]  = bus.m_hprot[g*4 +: 4];
        assign w_trans[g] = bus.m_htrans[g*2 +: 2];
    end

    // Rotation distance from last_owner+1; the nearest requester wins, so indices >= NUM_MASTERS never appear
    always_comb begin
        w_best   = NUM_MASTERS;
        w_winner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.m_bus_req[i] && (i + NUM_MASTERS - 1 - int'(r_last)) % NUM_MASTERS < w_best) begin
                w_best   = (i + NUM_MASTERS - 1 - int'(r_last)) % NUM_MASTERS;
                w_winner = OWNER_W'(i);
            end
        end
    end

    assign w_any = |bus.m_bus_req;
    assign w_own = r_state == OWN;

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_last  = r_last;
        case (r_state)
            IDLE: begin
                w_next_state = w_any ? OWN : IDLE;
                w_next_owner = w_any ? w_winner : r_owner;
            end
            OWN: begin
                if (!bus.m_bus_req[r_owner] && !bus.m_hmastlock[r_owner]) begin
                    w_next_state = DRAIN;
                    w_next_last  = r_owner;
                end
            end
            DRAIN: begin
                if (bus.hready) begin
                    w_next_state = w_any ? OWN : IDLE;
                    w_next_owner = w_any ? w_winner : r_owner;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last       <= OWNER_W'(NUM_MASTERS - 1);
            r_dph_active <= 1'b0;
            r_dph_owner  <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_last  <= w_next_last;
            if (bus.hready) begin
                r_dph_active <= w_own && bus.htrans[1];
                r_dph_owner  <= r_owner;
            end
        end
    end

    assign bus.m_bus_ack  = w_own ? (NUM_MASTERS'(1) << r_owner) : '0;
    assign bus.haddr      = w_own ? w_addr[r_owner] : '0;
    assign bus.hwrite     = w_own & bus.m_hwrite[r_owner];
    assign bus.hsize      = w_own ? w_size[r_owner] : '0;
    assign bus.hburst     = w_own ? w_burst[r_owner] : '0;
    assign bus.hprot      = w_own ? w_prot[r_owner] : '0;
    assign bus.htrans     = w_own ? w_trans[r_owner] : 2'b00;
    assign bus.hmastlock  = w_own & bus.m_hmastlock[r_owner];
    assign bus.hwdata     = r_dph_active ? w_wdata[r_dph_owner] : '0;
    assign bus.m_hready   = bus.hready;
    assign bus.m_hresp    = bus.hresp;
    assign bus.m_hreset_n = bus.hreset_n;
    assign bus.m_hrdata   = bus.hrdata;
    assign bus.owner_id   = r_owner;
    assign bus.bus_busy   = r_state != IDLE;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed vectors for a 3-master and a 5-master arbiter, checked through an expectation queue.
module tb_ahb_bus_arbiter;
    logic clk;
    logic rst_n;

    ahb_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(64), .DATA_W(64)) b3 ();
    ahb_bus_arbiter_if #(.NUM_MASTERS(5), .ADDR_W(64), .DATA_W(64)) b5 ();

    ahb_bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(64), .DATA_W(64)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    ahb_bus_arbiter #(.NUM_MASTERS(5), .ADDR_W(64), .DATA_W(64)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    typedef struct {
        int          dut;
        logic [7:0]  ack;
        logic [1:0]  htrans;
        logic        lock;
        logic [63:0] haddr;
        logic [63:0] hwdata;
        logic        busy;
        int          owner;
        logic [63:0] rdata;
        logic        hrdy;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ea(input int o);
        return (o == 0) ? 64'h1000 : (o == 1) ? 64'h100 : 64'h3000;
    endfunction

    function automatic logic [63:0] ed(input int o);
        return (o == 0) ? 64'hD000 : (o == 1) ? 64'hA5A5 : 64'hD002;
    endfunction

    task automatic cyc(input string n, input int d, input logic [7:0] ack, input logic [1:0] tr, input logic lk,
                       input logic [63:0] a, input logic [63:0] wd, input logic bsy, input int own);
        exp_t e;
        e.dut = d; e.ack = ack; e.htrans = tr; e.lock = lk; e.haddr = a; e.hwdata = wd;
        e.busy = bsy; e.owner = own;
        e.rdata = (d == 0) ? b3.hrdata : b5.hrdata;
        e.hrdy  = (d == 0) ? b3.hready : b5.hready;
        q.push_back(e);
        nq.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // n OWN cycles of master o with its request dropped in the last one, then the single DRAIN cycle
    task automatic tenure(input int o, input int n, input logic [2:0] req_on, input logic [2:0] req_after);
        for (int k = 0; k < n; k++) begin
            b3.m_bus_req = (k == n - 1) ? (req_on & ~(3'b001 << o)) : req_on;
            cyc($sformatf("rr_m%0d_own%0d", o, k), 0, 8'(1 << o), 2'b10, 1'b0, ea(o),
                (k == 0) ? 64'h0 : ed(o), 1'b1, o);
        end
        b3.m_bus_req = req_after;
        cyc($sformatf("rr_m%0d_drain", o), 0, 8'h00, 2'b00, 1'b0, 64'h0, ed(o), 1'b1, o);
    endtask

    exp_t        me;
    string       mn;
    logic [7:0]  a_ack;
    logic [1:0]  a_tr;
    logic        a_lk, a_busy, a_hr;
    logic [63:0] a_addr, a_wd, a_rd;
    int          a_own;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            mn = nq.pop_front();
            if (me.dut == 0) begin
                a_ack = {5'b0, b3.m_bus_ack}; a_tr = b3.htrans; a_lk = b3.hmastlock; a_addr = b3.haddr;
                a_wd = b3.hwdata; a_busy = b3.bus_busy; a_own = int'(b3.owner_id); a_rd = b3.m_hrdata; a_hr = b3.m_hready;
            end else begin
                a_ack = {3'b0, b5.m_bus_ack}; a_tr = b5.htrans; a_lk = b5.hmastlock; a_addr = b5.haddr;
                a_wd = b5.hwdata; a_busy = b5.bus_busy; a_own = int'(b5.owner_id); a_rd = b5.m_hrdata; a_hr = b5.m_hready;
            end
            checks++;
            if (a_ack !== me.ack || a_tr !== me.htrans || a_lk !== me.lock || a_addr !== me.haddr ||
                a_wd !== me.hwdata || a_busy !== me.busy || (me.owner >= 0 && a_own != me.owner) ||
                a_rd !== me.rdata || a_hr !== me.hrdy) begin
                errors++;
                $display("FAIL %s: got ack=%h htrans=%h lock=%b haddr=%h hwdata=%h busy=%b owner=%0d rdata=%h hready=%b, expected ack=%h htrans=%h lock=%b haddr=%h hwdata=%h busy=%b owner=%0d rdata=%h hready=%b",
                         mn, a_ack, a_tr, a_lk, a_addr, a_wd, a_busy, a_own, a_rd, a_hr,
                         me.ack, me.htrans, me.lock, me.haddr, me.hwdata, me.busy, me.owner, me.rdata, me.hrdy);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        b3.m_bus_req = 3'b111; b3.m_haddr = {ea(2), ea(1), ea(0)}; b3.m_hwdata = {ed(2), ed(1), ed(0)};
        b3.m_hwrite = 3'b111; b3.m_hsize = '0; b3.m_hburst = '0; b3.m_hprot = '0;
        b3.m_htrans = {3{2'b10}}; b3.m_hmastlock = '0;
        b3.hready = 1'b1; b3.hresp = 1'b0; b3.hreset_n = 1'b1; b3.hrdata = 64'h1111;
        b5.m_bus_req = '0; b5.m_hwrite = '1; b5.m_hsize = '0; b5.m_hburst = '0; b5.m_hprot = '0;
        b5.m_htrans = {5{2'b10}}; b5.m_hmastlock = '0;
        b5.m_haddr  = {64'h504, 64'h503, 64'h502, 64'h501, 64'h500};
        b5.m_hwdata = {64'hB04, 64'hB03, 64'hB02, 64'hB01, 64'hB00};
        b5.hready = 1'b1; b5.hresp = 1'b0; b5.hreset_n = 1'b1; b5.hrdata = 64'h5555;
        @(posedge clk);
        #1;
        cyc("rst_1", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, 0);
        cyc("rst_2", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, 0);
        rst_n = 1'b1;
        cyc("rst_3", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, 0);
        tenure(0, 4, 3'b111, 3'b111);
        tenure(1, 4, 3'b111, 3'b111);
        tenure(2, 4, 3'b111, 3'b111);
        tenure(0, 4, 3'b111, 3'b000);
        b3.hrdata = 64'hDEAD_BEEF;
        cyc("idle_1", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, -1);
        cyc("idle_2", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, -1);
        b3.m_bus_req = 3'b010;
        cyc("dph_req", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, -1);
        b3.m_bus_req = 3'b100;
        cyc("dph_own", 0, 8'h02, 2'b10, 1'b0, 64'h100, 64'h0, 1'b1, 1);
        b3.hready = 1'b0;
        cyc("dph_wait1", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'hA5A5, 1'b1, 1);
        cyc("dph_wait2", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'hA5A5, 1'b1, 1);
        b3.hready = 1'b1;
        cyc("dph_last", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'hA5A5, 1'b1, 1);
        b3.m_bus_req = 3'b001;
        cyc("dph_m2_own", 0, 8'h04, 2'b10, 1'b0, 64'h3000, 64'h0, 1'b1, 2);
        cyc("m2_drain", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'hD002, 1'b1, 2);
        b3.m_bus_req = 3'b000;
        b3.m_hmastlock = 3'b001;
        cyc("lock_own", 0, 8'h01, 2'b10, 1'b1, 64'h1000, 64'h0, 1'b1, 0);
        b3.m_hmastlock = 3'b000;
        cyc("lock_hold", 0, 8'h01, 2'b10, 1'b0, 64'h1000, 64'hD000, 1'b1, 0);
        cyc("lock_drain", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'hD000, 1'b1, 0);
        cyc("lock_idle", 0, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, -1);
        b5.m_bus_req = 5'b10000;
        cyc("wrap_req", 1, 8'h00, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0, -1);
        b5.m_bus_req = 5'b01000;
        cyc("wrap_own4", 1, 8'h10, 2'b10, 1'b0, 64'h504, 64'h0, 1'b1, 4);
        cyc("wrap_drain", 1, 8'h00, 2'b00, 1'b0, 64'h0, 64'hB04, 1'b1, 4);
        cyc("wrap_own3", 1, 8'h08, 2'b10, 1'b0, 64'h503, 64'h0, 1'b1, 3);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Parametrised N-master AHB bus arbiter and multiplexer that sits between the core's bus units (L1, TLB walker, external/DMA masters) and the single outbound AHB port. It grants the bus with round-robin fairness using a per-master req/ack handshake. It switches owners only at safe transfer boundaries. It muxes both the address phase and the data phase, so write data always follows the master that issued the address. Unowned cycles drive IDLE transfers.

## Interface
- NUM_MASTERS, 3, number of requesting masters (2..8); master 0 has first priority after reset
- ADDR_W, 64, address width
- DATA_W, 64, data width
- OWNER_W, $clog2(NUM_MASTERS), owner index width (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- m_bus_req  in  NUM_MASTERS  per-master bus request, level, held for whole tenure
- m_bus_ack  out  NUM_MASTERS  per-master grant, one-hot or zero
- m_haddr  in  NUM_MASTERS*ADDR_W  packed per-master address (master i at [i*ADDR_W +: ADDR_W])
- m_hwrite  in  NUM_MASTERS  per-master write
- m_hsize  in  NUM_MASTERS*4  per-master size
- m_hburst  in  NUM_MASTERS*3  per-master burst
- m_hprot  in  NUM_MASTERS*4  per-master protection
- m_htrans  in  NUM_MASTERS*2  per-master transfer type
- m_hmastlock  in  NUM_MASTERS  per-master lock
- m_hwdata  in  NUM_MASTERS*DATA_W  per-master write data
- m_hready, m_hresp, m_hreset_n  out  1 each  broadcast copies of hready/hresp/hreset_n
- m_hrdata  out  DATA_W  broadcast copy of hrdata
- haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata  out  ADDR_W,1,4,3,4,2,1,DATA_W  AHB master port
- hready, hresp, hreset_n  in  1 each  AHB response
- hrdata  in  DATA_W  AHB read data
- owner_id  out  OWNER_W  current address-phase owner (valid when bus_busy)
- bus_busy  out  1  high in OWN or DRAIN

## Operation
- States: IDLE, OWN, DRAIN. Registers: state, owner, last_owner, dph_active, dph_owner.
- IDLE: if any m_bus_req, then owner <= winner and state <= OWN. Else hold.
- Winner: the first requester scanning from last_owner+1 upward, modulo NUM_MASTERS.
- OWN: m_bus_ack[owner]=1. Address/control outputs come combinationally from master owner.
- OWN -> DRAIN when !m_bus_req[owner] && !m_hmastlock[owner]. On this transition, last_owner <= owner.
- A request held with hmastlock high keeps ownership. The lock also blocks release.
- DRAIN: ack low. Outputs htrans=2'b00, hmastlock=0, and the other address/control outputs are 0.
- DRAIN exits when hready=1. If any request is pending, go to OWN with a new winner, chosen against the updated last_owner. Otherwise go to IDLE.
- IDLE outputs match DRAIN outputs (IDLE transfer, zeros).
- Data phase: when hready=1, dph_active <= (state==OWN && htrans_out[1]) and dph_owner <= owner.
- hwdata = dph_active ? m_hwdata[dph_owner] : 0.
- Responses (hready, hresp, hrdata, hreset_n) are broadcast unmodified to all masters. Each master qualifies them by its own ack or outstanding transfer.

## Timing
- Reset (rst_n=0 at posedge): state=IDLE, owner=0, last_owner=NUM_MASTERS-1, dph_active=0, dph_owner=0.
- Outputs during and after reset: m_bus_ack=0, htrans=0, hmastlock=0, haddr=0, hwdata=0, owner_id=0, bus_busy=0.
- Reset mid-transfer drops ack and ownership at the next edge with no drain.
- Grant latency from IDLE: req sampled high at edge t gives ack high after edge t (one cycle). The first address phase can appear in that cycle.
- Handover: owner drops req before edge t, giving DRAIN after t. If hready=1 in that DRAIN cycle, the new ack is high after t+1. Minimum of one dead cycle between owners.
- If hready=0 in DRAIN (slave wait state on the last data phase), DRAIN holds. hwdata keeps following dph_owner until that data phase completes.
- A request dropped in the same cycle as ack rises: OWN lasts one cycle, then DRAIN.
- Simultaneous requests: the round-robin winner is taken. Losers hold req and are served in rotation order. No master starves with NUM_MASTERS-1 intervening tenures.
- NUM_MASTERS not a power of two: the scan wraps at NUM_MASTERS-1 to 0. Out-of-range indices never win.

## Test plan
- Reset: hold rst_n=0 three cycles with all req=1 -> ack=0, htrans=0, bus_busy=0. First ack goes to master 0 one cycle after rst_n=1.
- Round robin: NUM_MASTERS=3, all req held, each master releases after 4 cycles -> grant order 0,1,2,0. Exactly one DRAIN cycle between tenures when hready=1.
- Data-phase steering: master 1 issues a NONSEQ write to addr 0x100 in its last OWN cycle with hwdata 0xA5A5, and the slave adds 2 wait states -> DRAIN lasts 3 cycles. hwdata=0xA5A5 throughout. Master 2 is not acked until hready=1.
- Lock: master 0 drops req with hmastlock=1 -> stays OWN. Drops hmastlock one cycle later -> DRAIN next cycle.
- Idle bus: no requests -> htrans=2'b00, haddr=0, hwdata=0 every cycle. Broadcast hrdata=0xDEAD_BEEF appears on m_hrdata the same cycle.
- NUM_MASTERS=5, last_owner=4, req only from 3 -> wrap scan grants master 3 after one DRAIN cycle.
